// File: rtl/add_subt_norm_pkg.sv
// Shared widths, case encoding and S1->S2 payload for the add/subtract
// post-normalization stage.
package add_subt_norm_pkg;

  localparam int unsigned W  = 55;  // significand width
  localparam int unsigned EW = 11;  // exponent width
  localparam int unsigned SW = 6;   // shift-count width, ceil(log2(W))

  // How a beat is resolved in S1
  typedef enum logic [1:0] {
    CASE_NORMAL,
    CASE_UFLOW,
    CASE_ZERO
  } norm_case_t;

  // Payload carried from S1 to S2; shift is the effective shift e
  typedef struct packed {
    logic [W-1:0]  mant;
    logic [EW-1:0] exp;
    logic [SW-1:0] shift;
    logic          zero;
    logic          uflow;
    logic          err;
  } norm_s1_t;

endpackage

// File: rtl/norm_barrel_lshift.sv
// Combinational logarithmic left shifter: SW mux levels, level k shifts by
// 2**k when amt[k] is set. Vacated LSBs are zero-filled.
module norm_barrel_lshift #(
  parameter int unsigned W  = 55,
  parameter int unsigned SW = 6
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  dout
);

  logic [W-1:0] lvl [SW+1];

  assign lvl[0] = din;

  // One conditional power-of-two shift per bit of the shift amount
  for (genvar k = 0; k < SW; k++) begin : g_lvl
    assign lvl[k+1] = amt[k] ? (lvl[k] << (1 << k)) : lvl[k];
  end

  assign dout = lvl[SW];

endmodule

// File: rtl/add_subt_normalizer.sv
// Post-subtraction normalizer: two-stage valid/ready pipeline.
// S1 classifies the beat (normal / underflow / zero) and resolves the
// effective shift and adjusted exponent; S2 applies the left shift.
// Optional encoder/data consistency checker: define FPU_NORM_CHECK_EN.
module add_subt_normalizer
  import add_subt_norm_pkg::*;
#(
  parameter int unsigned W  = add_subt_norm_pkg::W,
  parameter int unsigned EW = add_subt_norm_pkg::EW,
  parameter int unsigned SW = add_subt_norm_pkg::SW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [W-1:0]  Mant_i,
  input  logic [EW-1:0] Exp_i,
  input  logic [SW-1:0] Shift_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [W-1:0]  Mant_o,
  output logic [EW-1:0] Exp_o,
  output logic          Zero_o,
  output logic          Uflow_o,
  output logic          Shift_Err_o
);

  norm_case_t    in_case;
  norm_s1_t      in_pl;
  logic [EW-1:0] shift_ext;
  logic          in_err;

  logic          s1_v;
  logic          s2_v;
  logic          s2_adv;
  norm_s1_t      s1_q;
  logic [W-1:0]  sh_out;

  assign shift_ext = EW'(Shift_i);

  // Classify the incoming beat; zero has priority over underflow
  always_comb begin
    if (Mant_i == '0 || 32'(Shift_i) >= W) begin
      in_case = CASE_ZERO;
    end else if (shift_ext < Exp_i) begin
      in_case = CASE_NORMAL;
    end else begin
      in_case = CASE_UFLOW;
    end
  end

  // Resolve effective shift, exponent and flags for the S1 payload.
  // Underflow shifts by Exp_i-1 so the result lands on the subnormal
  // boundary; Exp_i <= Shift_i < W there, so the shift fits SW bits.
  always_comb begin
    in_pl      = '0;
    in_pl.mant = Mant_i;
    in_pl.err  = in_err;
    unique case (in_case)
      CASE_NORMAL: begin
        in_pl.exp   = Exp_i - shift_ext;
        in_pl.shift = Shift_i;
      end
      CASE_UFLOW: begin
        in_pl.shift = (Exp_i == '0) ? '0 : SW'(Exp_i - EW'(1));
        in_pl.uflow = 1'b1;
      end
      default: begin
        in_pl.mant = '0;
        in_pl.zero = 1'b1;
      end
    endcase
  end

`ifdef FPU_NORM_CHECK_EN
  logic [31:0] lead_pos;

  // The leading one must sit exactly at W-1-Shift_i with nothing above it
  always_comb begin
    lead_pos = W - 1 - 32'(Shift_i);
    in_err   = (in_case != CASE_ZERO) && ((Mant_i >> lead_pos) != W'(1));
  end
`else
  assign in_err = 1'b0;
`endif

  // S2 can take a beat when empty or when its beat leaves this cycle;
  // S1 can take one when empty or when it moves into S2.
  assign s2_adv  = !s2_v || ready_i;
  assign ready_o = !s1_v || s2_adv;
  assign valid_o = s2_v;

  // S1 register: valid bit plus resolved payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0;
      s1_q <= '0;
    end else if (ready_o) begin
      s1_v <= valid_i;
      if (valid_i) begin
        s1_q <= in_pl;
      end
    end
  end

  norm_barrel_lshift #(
    .W  (W),
    .SW (SW)
  ) u_lshift (
    .din  (s1_q.mant),
    .amt  (s1_q.shift),
    .dout (sh_out)
  );

  // S2 register: shifted significand and flags drive the outputs directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v    <= 1'b0;
      Mant_o  <= '0;
      Exp_o   <= '0;
      Zero_o  <= 1'b0;
      Uflow_o <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        Mant_o  <= sh_out;
        Exp_o   <= s1_q.exp;
        Zero_o  <= s1_q.zero;
        Uflow_o <= s1_q.uflow;
      end
    end
  end

`ifdef FPU_NORM_CHECK_EN
  // Checker flag travels with its beat's data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Shift_Err_o <= 1'b0;
    end else if (s2_adv && s1_v) begin
      Shift_Err_o <= s1_q.err;
    end
  end
`else
  logic unused_s1_err;
  assign unused_s1_err = s1_q.err;
  assign Shift_Err_o   = 1'b0;
`endif

endmodule
